// File: rtl/lfsr_pkg.sv
// Shared state and command encodings for the LFSR sequencing controller.
package lfsr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_MATCH = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_RUN   = 2'b01,
    OP_MATCH = 2'b10,
    OP_RSVD  = 2'b11
  } op_t;

  // States in which a command is executing and abort is honoured.
  function automatic logic is_active(state_t s);
    return (s == ST_LOAD) || (s == ST_RUN) || (s == ST_MATCH);
  endfunction

endpackage

// File: rtl/lfsr_seq_ctrl_if.sv
// Command handshake bundle for lfsr_seq_ctrl (valid/ready plus op, data, len).
interface lfsr_seq_ctrl_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [CNT_W-1:0] cmd_len;

  modport master (
    output cmd_valid, cmd_op, cmd_data, cmd_len,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, cmd_len,
    output cmd_ready
  );
endinterface

// File: rtl/lfsr_step_cnt.sv
// Saturating step counter: synchronous clear, increment, holds at all-ones.
module lfsr_step_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] value
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (inc && (value != '1)) begin
      value <= value + CNT_W'(1);
    end
  end

endmodule

// File: rtl/lfsr_seq_ctrl.sv
// Sequencer driving an external LFSR through LOAD / RUN / MATCH commands.
// Optional MATCH timeout enabled by macro LFSR_SEQ_CTRL_TIMEOUT_EN. Requires CNT_W >= WIDTH.
module lfsr_seq_ctrl
  import lfsr_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  lfsr_seq_ctrl_if.slave    cmd,
  input  logic              abort,
  output logic [WIDTH-1:0]  lfsr_data,
  output logic              lfsr_cen,
  output logic              lfsr_load_n,
  input  logic [WIDTH-1:0]  lfsr_count,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [CNT_W-1:0]  steps
);

  state_t           state;
  state_t           state_nx;
  op_t              op_in;
  logic [WIDTH-1:0] target;
  logic [CNT_W-1:0] len_left;
  logic             accept;
  logic             hit;
  logic             timeout;
  logic             step_inc;

  assign op_in  = op_t'(cmd.cmd_op);
  assign accept = cmd.cmd_valid && cmd.cmd_ready;
  assign hit    = (lfsr_count == target);

`ifdef LFSR_SEQ_CTRL_TIMEOUT_EN
  // steps equals the enabled MATCH cycles so far; this edge issues the last allowed one.
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((1 << WIDTH) - 2);
  assign timeout = (state == ST_MATCH) && lfsr_cen && (steps == TMO_LAST);
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          case (op_in)
            OP_LOAD:  state_nx = ST_LOAD;
            OP_RUN:   state_nx = (cmd.cmd_len == '0) ? ST_DONE : ST_RUN;
            OP_MATCH: state_nx = ST_MATCH;
            default:  state_nx = ST_DONE;
          endcase
        end
      end
      ST_LOAD:  state_nx = ST_DONE;
      ST_RUN:   if (abort || (len_left == CNT_W'(1))) state_nx = ST_DONE;
      ST_MATCH: if (hit || abort || timeout) state_nx = ST_DONE;
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd.cmd_ready = 1'b0;
    busy          = 1'b1;
    done          = 1'b0;
    lfsr_cen      = 1'b0;
    lfsr_load_n   = 1'b1;
    case (state)
      ST_IDLE: begin
        cmd.cmd_ready = 1'b1;
        busy          = 1'b0;
      end
      ST_LOAD: begin
        lfsr_cen    = 1'b1;
        lfsr_load_n = 1'b0;
      end
      // An aborting cycle must not advance the LFSR, so it is not a step either.
      ST_RUN:   lfsr_cen = !abort;
      ST_MATCH: lfsr_cen = !hit && !abort;
      ST_DONE:  done = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      target   <= cmd.cmd_data;
      len_left <= cmd.cmd_len;
    end else if (state == ST_RUN) begin
      len_left <= len_left - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_data <= '0;
      err       <= 1'b0;
    end else if (accept) begin
      err <= (op_in == OP_RSVD);
      if (op_in == OP_LOAD) lfsr_data <= cmd.cmd_data;
    end else if (is_active(state) && (abort || timeout) && !((state == ST_MATCH) && hit)) begin
      err <= 1'b1;
    end
  end

  assign step_inc = lfsr_cen && ((state == ST_RUN) || (state == ST_MATCH));

  lfsr_step_cnt #(
    .CNT_W (CNT_W)
  ) u_step_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (accept),
    .inc   (step_inc),
    .value (steps)
  );

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Directed bench for lfsr_seq_ctrl with a 4-bit x^4+x^3+1 LFSR attached.
module tb_lfsr_seq_ctrl;
  import lfsr_pkg::*;

  localparam int WIDTH = 4;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             abort;
  logic [WIDTH-1:0] lfsr_data;
  logic [WIDTH-1:0] lfsr_count;
  logic             lfsr_cen;
  logic             lfsr_load_n;
  logic             busy;
  logic             done;
  logic             err;
  logic [CNT_W-1:0] steps;

  int checks = 0;
  int errors = 0;
  int cen_tot = 0;
  int load_tot = 0;
  int done_tot = 0;

  lfsr_seq_ctrl_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) cif ();

  lfsr_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd         (cif),
    .abort       (abort),
    .lfsr_data   (lfsr_data),
    .lfsr_cen    (lfsr_cen),
    .lfsr_load_n (lfsr_load_n),
    .lfsr_count  (lfsr_count),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .steps       (steps)
  );

  always #5 clk = ~clk;

  // Sequence from seed 4: 4 -> 9 -> 3 -> 6; never reaches 0 from a nonzero seed.
  always @(posedge clk or posedge rst) begin
    if (rst) lfsr_count <= '0;
    else if (!lfsr_load_n) lfsr_count <= lfsr_data;
    else if (lfsr_cen) lfsr_count <= {lfsr_count[2:0], lfsr_count[3] ^ lfsr_count[2]};
  end

  always @(posedge clk) begin
    if (lfsr_cen) cen_tot <= cen_tot + 1;
    if (!lfsr_load_n) load_tot <= load_tot + 1;
    if (done) done_tot <= done_tot + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [3:0] d, input logic [7:0] l);
    cif.cmd_valid = 1'b1;
    cif.cmd_op    = op;
    cif.cmd_data  = d;
    cif.cmd_len   = l;
    @(negedge clk);
    cif.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    chk("done_reached", {31'd0, done}, 1);
  endtask

  task automatic chk_reset_values(input string pfx);
    chk({pfx, "_ready"}, {31'd0, cif.cmd_ready}, 1);
    chk({pfx, "_busy"}, {31'd0, busy}, 0);
    chk({pfx, "_done"}, {31'd0, done}, 0);
    chk({pfx, "_err"}, {31'd0, err}, 0);
    chk({pfx, "_steps"}, {24'd0, steps}, 0);
    chk({pfx, "_cen"}, {31'd0, lfsr_cen}, 0);
    chk({pfx, "_load_n"}, {31'd0, lfsr_load_n}, 1);
    chk({pfx, "_lfsr_data"}, {28'd0, lfsr_data}, 0);
  endtask

  initial begin
    int cyc;
    int c0;
    int l0;
    int d0;

    rst           = 1'b1;
    abort         = 1'b0;
    cif.cmd_valid = 1'b0;
    cif.cmd_op    = 2'b00;
    cif.cmd_data  = '0;
    cif.cmd_len   = '0;
    repeat (2) @(negedge clk);
    chk_reset_values("rst0");
    rst = 1'b0;
    @(negedge clk);

    // LOAD seed 4
    l0 = load_tot;
    issue(OP_LOAD, 4'd4, 8'd0);
    chk("load_n_low", {31'd0, lfsr_load_n}, 0);
    chk("load_data", {28'd0, lfsr_data}, 4);
    chk("load_cen", {31'd0, lfsr_cen}, 1);
    chk("load_not_ready", {31'd0, cif.cmd_ready}, 0);
    wait_done(5, cyc);
    chk("load_latency", cyc, 1);
    chk("load_steps", {24'd0, steps}, 0);
    chk("load_err", {31'd0, err}, 0);
    chk("load_cycles", load_tot - l0, 1);
    @(negedge clk);
    chk("seed_in_lfsr", {28'd0, lfsr_count}, 4);
    chk("idle_ready", {31'd0, cif.cmd_ready}, 1);
    chk("done_one_cycle", {31'd0, done}, 0);
    chk("data_held", {28'd0, lfsr_data}, 4);

    // RUN 10 then RUN 0
    c0 = cen_tot;
    issue(OP_RUN, 4'd0, 8'd10);
    wait_done(30, cyc);
    chk("run10_latency", cyc, 10);
    chk("run10_cen", cen_tot - c0, 10);
    chk("run10_steps", {24'd0, steps}, 10);
    chk("run10_err", {31'd0, err}, 0);
    @(negedge clk);
    c0 = cen_tot;
    issue(OP_RUN, 4'd0, 8'd0);
    wait_done(5, cyc);
    chk("run0_latency", cyc, 0);
    chk("run0_cen", cen_tot - c0, 0);
    chk("run0_steps", {24'd0, steps}, 0);
    @(negedge clk);

    // LOAD 4 then MATCH 6 (three steps away)
    issue(OP_LOAD, 4'd4, 8'd0);
    wait_done(5, cyc);
    @(negedge clk);
    c0 = cen_tot;
    issue(OP_MATCH, 4'd6, 8'd0);
    wait_done(30, cyc);
    chk("match_cen", cen_tot - c0, 3);
    chk("match_steps", {24'd0, steps}, 3);
    chk("match_err", {31'd0, err}, 0);
    chk("match_lfsr", {28'd0, lfsr_count}, 6);
    @(negedge clk);

    // MATCH already equal with abort held high: match wins
    abort = 1'b1;
    c0 = cen_tot;
    issue(OP_MATCH, 4'd6, 8'd0);
    chk("hit_abort_cen", {31'd0, lfsr_cen}, 0);
    wait_done(3, cyc);
    chk("hit_abort_latency", cyc, 1);
    chk("hit_abort_err", {31'd0, err}, 0);
    chk("hit_abort_steps", {24'd0, steps}, 0);
    @(negedge clk);
    chk("abort_in_done_ignored", {31'd0, err}, 0);
    chk("back_to_idle", {31'd0, cif.cmd_ready}, 1);
    abort = 1'b0;

    // RUN 10 aborted after 4 enabled cycles
    c0 = cen_tot;
    issue(OP_RUN, 4'd0, 8'd10);
    repeat (4) @(negedge clk);
    abort = 1'b1;
    #1;
    chk("abort_cen_off", {31'd0, lfsr_cen}, 0);
    @(negedge clk);
    abort = 1'b0;
    chk("abort_done", {31'd0, done}, 1);
    chk("abort_steps", {24'd0, steps}, 4);
    chk("abort_err", {31'd0, err}, 1);
    chk("abort_cen", cen_tot - c0, 4);
    @(negedge clk);

    // Reserved opcode
    c0 = cen_tot;
    issue(OP_RSVD, 4'd0, 8'd0);
    chk("rsvd_done", {31'd0, done}, 1);
    chk("rsvd_err", {31'd0, err}, 1);
    chk("rsvd_cen", cen_tot - c0, 0);
    @(negedge clk);
    chk("err_held", {31'd0, err}, 1);

    // MATCH on an unreachable target
    c0 = cen_tot;
    issue(OP_MATCH, 4'd0, 8'd0);
    chk("err_cleared", {31'd0, err}, 0);
`ifdef LFSR_SEQ_CTRL_TIMEOUT_EN
    wait_done(40, cyc);
    chk("tmo_cen", cen_tot - c0, 15);
    chk("tmo_steps", {24'd0, steps}, 15);
    chk("tmo_err", {31'd0, err}, 1);
`else
    repeat (20) @(negedge clk);
    chk("no_tmo_busy", {31'd0, busy}, 1);
    chk("no_tmo_steps", {24'd0, steps}, 20);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("no_tmo_abort_done", {31'd0, done}, 1);
    chk("no_tmo_abort_err", {31'd0, err}, 1);
    chk("no_tmo_cen", cen_tot - c0, 20);
`endif
    @(negedge clk);

    // Reset in the middle of RUN 10
    d0 = done_tot;
    issue(OP_RUN, 4'd0, 8'd10);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk_reset_values("rst_run");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("rst_no_done", done_tot - d0, 0);
    chk("rst_idle", {31'd0, busy}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lfsr_seq_ctrl.md
LFSR_SEQ_CTRL -- requirements
Module: lfsr_seq_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning the LFSR data/count width in bits.
REQ-002 SHALL have parameter CNT_W, default 8, meaning the step-counter width; legal only with CNT_W >= WIDTH.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port cmd_valid  input  1  command offered.
REQ-006 SHALL have port cmd_ready  output  1  command accepted when high together with cmd_valid.
REQ-007 SHALL have port cmd_op  input  2  command code: 00 LOAD, 01 RUN, 10 MATCH, 11 reserved.
REQ-008 SHALL have port cmd_data  input  WIDTH  seed for LOAD, target for MATCH.
REQ-009 SHALL have port cmd_len  input  CNT_W  step count for RUN.
REQ-010 SHALL have port abort  input  1  terminate the active command.
REQ-011 SHALL have port lfsr_data  output  WIDTH  seed driven to the LFSR.
REQ-012 SHALL have port lfsr_cen  output  1  LFSR count enable, active-high.
REQ-013 SHALL have port lfsr_load_n  output  1  LFSR load, active-low.
REQ-014 SHALL have port lfsr_count  input  WIDTH  current LFSR value.
REQ-015 SHALL have port busy  output  1  high in every state except IDLE.
REQ-016 SHALL have port done  output  1  one-cycle completion pulse.
REQ-017 SHALL have port err  output  1  status of the last command (abort or timeout); held until the next acceptance.
REQ-018 SHALL have port steps  output  CNT_W  number of lfsr_cen cycles issued by the last command; held until the next acceptance.

Function
REQ-019 SHALL implement the states IDLE, LOAD, RUN, MATCH and DONE.
REQ-020 SHALL drive cmd_ready high only in IDLE; a handshake on a rising edge latches op, data and len, clears err and steps, and moves to LOAD, RUN or MATCH.
REQ-021 SHALL treat cmd_op 11 as a no-op that goes directly to DONE with err=1.
REQ-022 LOAD SHALL last exactly one cycle with lfsr_load_n=0, lfsr_cen=1 and lfsr_data=latched seed, then go to DONE; steps stays 0.
REQ-023 RUN SHALL hold lfsr_cen=1 for exactly cmd_len consecutive cycles, incrementing steps each cycle, then go to DONE; cmd_len=0 SHALL go directly from IDLE to DONE with no lfsr_cen cycle.
REQ-024 MATCH SHALL drive lfsr_cen = (lfsr_count != target) combinationally, increment steps on each enabled cycle, and go to DONE on the edge where lfsr_count == target (zero steps if already equal).
REQ-025 DONE SHALL last exactly one cycle with done=1, lfsr_cen=0, lfsr_load_n=1, and then return to IDLE.
REQ-026 Outside LOAD, the block SHALL hold lfsr_load_n=1 and lfsr_data at its last value.
REQ-027 SHALL ignore cmd_valid while busy; the requester holds its command until cmd_ready.
REQ-028 abort sampled high in LOAD, RUN or MATCH SHALL move to DONE on that edge with err=1, and the LFSR enable SHALL not be counted for that cycle.
REQ-029 abort SHALL be ignored in IDLE and DONE.
REQ-030 When abort and a MATCH hit coincide, the match SHALL win and err SHALL be 0.
REQ-031 The steps counter SHALL saturate at 2^CNT_W-1 and SHALL never wrap.

Reset
REQ-032 While rst is high, in any state, the block SHALL force IDLE, cmd_ready=1, busy=0, done=0, err=0, steps=0, lfsr_cen=0, lfsr_load_n=1 and lfsr_data=0, with an in-flight command discarded.

Configuration
REQ-033 With macro LFSR_SEQ_CTRL_TIMEOUT_EN defined, MATCH SHALL go to DONE with err=1 after 2^WIDTH-1 enabled cycles without a match.
REQ-034 Without LFSR_SEQ_CTRL_TIMEOUT_EN, MATCH SHALL end only on a match, on abort or on reset.

Structure
REQ-035 The state enum and the cmd_op codes SHALL live in the shared package lfsr_pkg.
REQ-036 The saturating step counter SHALL be the sub-module lfsr_step_cnt (clear, increment, value).

Verification
REQ-037 Scenario: rst pulsed while in RUN with cmd_len=10 -> all outputs at reset values immediately, with no done pulse.
REQ-038 Scenario: LOAD with cmd_data=4 -> exactly one cycle of lfsr_load_n=0 with lfsr_data=4, done the next cycle, steps=0, err=0.
REQ-039 Scenario: RUN with cmd_len=10 -> exactly 10 lfsr_cen cycles, then done, steps=10, err=0; a following RUN with cmd_len=0 -> zero lfsr_cen cycles and done one cycle after acceptance.
REQ-040 Scenario: LOAD seed 4, then MATCH with the target the bench model predicts 3 steps from 4 -> 3 lfsr_cen cycles, steps=3, err=0.
REQ-041 Scenario: RUN with cmd_len=10 and abort after 4 enabled cycles -> DONE, steps=4, err=1.
REQ-042 Scenario: MATCH with an unreachable target and LFSR_SEQ_CTRL_TIMEOUT_EN defined -> 15 lfsr_cen cycles, done, err=1.
